// File: rtl/fb_pkg.sv
// Shared geometry, state encoding and address type for the ping-pong frame buffer sequencer.
package fb_pkg;
  localparam int FB_W       = 160;
  localparam int FB_H       = 120;
  localparam int FB_DEPTH   = FB_W * FB_H;
  localparam int SCALE_LOG2 = 2;
  localparam int HPIXELS    = 640;
  localparam int VPIXELS    = 480;
  localparam logic [7:0] CLEAR_COLOR = 8'h00;

  typedef enum logic [1:0] {CLEAR, DRAW, WAIT_SWAP} fb_state_t;
  typedef logic [15:0] fb_addr_t;
endpackage

// File: rtl/fb_addr_calc.sv
// Linear frame-buffer address from buffer coordinates: y*FB_W + x, 16-bit unsigned.
module fb_addr_calc
  import fb_pkg::*;
(
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic [15:0] addr
);

  assign addr = ({8'd0, y} * 16'(FB_W)) + {8'd0, x};

endmodule

// File: rtl/fb_swap_ctrl.sv
// Ping-pong frame buffer sequencer: clears the back buffer, arbitrates renderer writes,
// swaps buffers at end of visible frame and generates the scaled scan-out address.
//   state     | meaning
//   CLEAR     | writing CLEAR_COLOR to every back-buffer address
//   DRAW      | renderer owns the back buffer
//   WAIT_SWAP | renderer done, waiting for frame_end to swap
module fb_swap_ctrl
  import fb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  vga_h,
  input  logic [9:0]  vga_v,
  input  logic        draw_req,
  input  logic [7:0]  draw_x,
  input  logic [6:0]  draw_y,
  input  logic [7:0]  draw_data,
  input  logic        draw_done,
  output logic        draw_ack,
  output logic        frame_start,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        buf_sel,
  output logic [15:0] rd_addr,
  output logic [7:0]  frames_dropped
);

  if (FB_DEPTH > 65536) begin : g_depth_chk
    $error("fb_swap_ctrl: FB_W*FB_H exceeds the 16-bit address space");
  end

  fb_state_t state, next_state;
  fb_addr_t  clear_cnt;
  fb_addr_t  draw_addr, scan_addr;
  logic      frame_end, last_clear, draw_in_range, scan_in_range;

  assign frame_end     = (vga_h == 10'(HPIXELS - 1)) && (vga_v == 10'(VPIXELS - 1));
  assign last_clear    = (clear_cnt == 16'(FB_DEPTH - 1));
  assign draw_in_range = (draw_x < 8'(FB_W)) && (draw_y < 7'(FB_H));
  assign scan_in_range = (vga_h < 10'(HPIXELS)) && (vga_v < 10'(VPIXELS));

  fb_addr_calc u_wr_calc (
    .x    (draw_x),
    .y    ({1'b0, draw_y}),
    .addr (draw_addr)
  );

  fb_addr_calc u_rd_calc (
    .x    (8'(vga_h >> SCALE_LOG2)),
    .y    (8'(vga_v >> SCALE_LOG2)),
    .addr (scan_addr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= CLEAR;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    draw_ack   = 1'b0;
    case (state)
      CLEAR:     if (last_clear) next_state = DRAW;
      DRAW: begin
        draw_ack = rst_n & draw_req;
        if (draw_done) next_state = WAIT_SWAP;
      end
      WAIT_SWAP: if (frame_end) next_state = CLEAR;
      default:   next_state = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clear_cnt      <= '0;
      buf_sel        <= 1'b0;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      frame_start    <= 1'b0;
      frames_dropped <= '0;
      rd_addr        <= '0;
    end else begin
      wr_en       <= 1'b0;
      frame_start <= (state == CLEAR) && last_clear;
      rd_addr     <= scan_in_range ? scan_addr : '0;
      case (state)
        CLEAR: begin
          wr_en     <= 1'b1;
          wr_addr   <= clear_cnt;
          wr_data   <= CLEAR_COLOR;
          clear_cnt <= clear_cnt + 16'd1;
        end
        DRAW: begin
          // Out-of-range requests are acknowledged but never reach the RAM.
          if (draw_ack && draw_in_range) begin
            wr_en   <= 1'b1;
            wr_addr <= draw_addr;
            wr_data <= draw_data;
          end
        end
        WAIT_SWAP: begin
          if (frame_end) begin
            buf_sel   <= ~buf_sel;
            clear_cnt <= '0;
          end
        end
        default: ;
      endcase
      // A frame_end outside WAIT_SWAP means the same front buffer is shown again.
      if (frame_end && (state != WAIT_SWAP) && (frames_dropped != 8'hFF))
        frames_dropped <= frames_dropped + 8'd1;
    end
  end

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Directed scoreboard bench for fb_swap_ctrl: expected writes queued by stimulus, popped by a monitor.
module tb_fb_swap_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  vga_h, vga_v;
  logic        draw_req, draw_done;
  logic [7:0]  draw_x, draw_data;
  logic [6:0]  draw_y;
  logic        draw_ack, frame_start, wr_en, buf_sel;
  logic [15:0] wr_addr, rd_addr;
  logic [7:0]  wr_data, frames_dropped;

  int checks   = 0;
  int failures = 0;
  logic [23:0] exp_q[$];

  fb_swap_ctrl dut (
    .clk(clk), .rst_n(rst_n), .vga_h(vga_h), .vga_v(vga_v),
    .draw_req(draw_req), .draw_x(draw_x), .draw_y(draw_y), .draw_data(draw_data),
    .draw_done(draw_done), .draw_ack(draw_ack), .frame_start(frame_start),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .buf_sel(buf_sel),
    .rd_addr(rd_addr), .frames_dropped(frames_dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic push_clear();
    for (int a = 0; a < 19200; a++) exp_q.push_back({16'(a), 8'h00});
  endtask

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write", wr_addr, wr_data);
      end else begin
        check("wr_addr_data", {8'h00, wr_addr, wr_data}, {8'h00, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int wr_cnt, fs_cnt;
    bit done;
    rst_n = 1'b0; vga_h = 10'd700; vga_v = 10'd0;
    draw_req = 1'b1; draw_x = 8'd200; draw_y = 7'd0; draw_data = 8'h00; draw_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_buf_sel", buf_sel, 0);
    check("rst_dropped", frames_dropped, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_draw_ack", draw_ack, 0);

    // Initial clear: 19200 back-to-back writes, one frame_start, no acks.
    push_clear();
    rst_n = 1'b1;
    wr_cnt = 0; fs_cnt = 0; done = 0;
    for (int i = 0; i < 25000 && !done; i++) begin
      @(negedge clk);
      if (wr_en) wr_cnt++;
      if (frame_start) fs_cnt++;
      else if (wr_en) check("clear_draw_ack", draw_ack, 0);
      if (wr_cnt > 0 && !wr_en) done = 1;
    end
    if (!done) timeout("clear_end");
    draw_req = 1'b0;
    check("clear_wr_cycles", wr_cnt, 19200);
    check("clear_frame_start_pulses", fs_cnt, 1);

    // In-range draw.
    draw_req = 1'b1; draw_x = 8'd5; draw_y = 7'd2; draw_data = 8'hA5;
    exp_q.push_back({16'd325, 8'hA5});
    #1 check("draw_ack_in_range", draw_ack, 1);
    @(negedge clk);
    draw_req = 1'b0;
    check("draw_wr_en", wr_en, 1);
    @(negedge clk);
    check("draw_wr_en_one_cycle", wr_en, 0);

    // Out-of-range x and y.
    draw_req = 1'b1; draw_x = 8'd200; draw_y = 7'd3;
    #1 check("draw_ack_x_oor", draw_ack, 1);
    @(negedge clk);
    check("wr_en_x_oor", wr_en, 0);
    draw_x = 8'd0; draw_y = 7'd120;
    #1 check("draw_ack_y_oor", draw_ack, 1);
    @(negedge clk);
    draw_req = 1'b0;
    check("wr_en_y_oor", wr_en, 0);

    // Missed frame: count the drop, no swap, remain in DRAW.
    vga_h = 10'd639; vga_v = 10'd479;
    @(negedge clk);
    vga_h = 10'd700; vga_v = 10'd0;
    check("drop_one", frames_dropped, 1);
    check("drop_no_swap", buf_sel, 0);
    check("drop_rd_addr_last", rd_addr, 19199);
    draw_req = 1'b1; draw_x = 8'd0; draw_y = 7'd0; draw_data = 8'h11;
    exp_q.push_back({16'd0, 8'h11});
    #1 check("drop_still_draw", draw_ack, 1);
    @(negedge clk);
    draw_req = 1'b0;
    vga_h = 10'd639; vga_v = 10'd479;
    repeat (299) @(negedge clk);
    vga_h = 10'd700; vga_v = 10'd0;
    check("drop_saturate", frames_dropped, 255);
    check("drop_sat_no_swap", buf_sel, 0);

    // draw_done with a simultaneous write, then swap on frame_end.
    draw_done = 1'b1; draw_req = 1'b1; draw_x = 8'd1; draw_y = 7'd0; draw_data = 8'h3C;
    exp_q.push_back({16'd1, 8'h3C});
    #1 check("done_write_ack", draw_ack, 1);
    @(negedge clk);
    draw_done = 1'b0; draw_x = 8'd2;
    #1 check("wait_swap_ack", draw_ack, 0);
    draw_req = 1'b0;
    check("pre_swap_buf_sel", buf_sel, 0);
    push_clear();
    vga_h = 10'd639; vga_v = 10'd479;
    @(negedge clk);
    vga_h = 10'd700; vga_v = 10'd0;
    check("swap_buf_sel", buf_sel, 1);
    check("swap_dropped_held", frames_dropped, 255);

    // Reset in the middle of the new clear, at clear_cnt 1000.
    done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (wr_en && wr_addr == 16'd999) done = 1;
    end
    if (!done) timeout("clear_reach_999");
    check("clear_buf_sel_held", buf_sel, 1);
    #1;
    exp_q.delete();
    rst_n = 1'b0; draw_req = 1'b1; draw_x = 8'd200;
    repeat (2) @(negedge clk);
    check("rst2_wr_en", wr_en, 0);
    check("rst2_buf_sel", buf_sel, 0);
    check("rst2_dropped", frames_dropped, 0);
    check("rst2_draw_ack", draw_ack, 0);
    draw_req = 1'b0;
    push_clear();
    vga_h = 10'd640; vga_v = 10'd10;
    rst_n = 1'b1;
    @(negedge clk);
    check("rd_addr_h_oor", rd_addr, 0);
    vga_h = 10'd7; vga_v = 10'd9;
    @(negedge clk);
    check("rd_addr_scaled", rd_addr, 321);
    vga_h = 10'd700; vga_v = 10'd0;
    done = 0;
    for (int i = 0; i < 25000 && !done; i++) begin
      @(negedge clk);
      if (frame_start) done = 1;
    end
    if (!done) timeout("clear2_frame_start");
    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
